// File: rtl/mem_tile_pkg.sv
// Shared encodings for the memory-tile arbiter: tile access modes, sequencer
// states and requester IDs.
package mem_tile_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_BYTE  = 3'd1;
  localparam logic [2:0] MD_WORD  = 3'd2;
  localparam logic [2:0] MD_DWORD = 3'd3;
  localparam logic [2:0] MD_QWORD = 3'd4;
  localparam logic [2:0] MD_OWORD = 3'd5;
  localparam logic [2:0] MD_UBYTE = 3'd6;
  localparam logic [2:0] MD_UWORD = 3'd7;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // The tile has no 128-bit path, so OWORD is rejected alongside NONE.
  function automatic logic mode_legal(input logic [2:0] mode);
    return !(mode == MD_NONE || mode == MD_OWORD);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on a tie the port not granted last time wins.
module rr_arb2
  import mem_tile_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant_valid,
  output logic       grant
);

  logic last_grant;

  always_comb begin
    grant_valid = |req;
    if (req[PORT_A] && req[PORT_B]) begin
      grant = ~last_grant;
    end else if (req[PORT_B]) begin
      grant = PORT_B;
    end else begin
      grant = PORT_A;
    end
  end

  // Resetting to B lets A win the very first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= PORT_B;
    end else if (accept && grant_valid) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/mem_tile_arb.sv
// Arbiter and sequencer in front of the single-ported 64-bit memory tile:
// grants A (fetch, read-only) or B (data), issues one strobe, waits, acks.
module mem_tile_arb
  import mem_tile_pkg::*;
#(
  parameter logic [33:0] TILE_BASE = 34'h0,
  parameter int unsigned TILE_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        aReq,
  input  logic [2:0]  aMode,
  input  logic [47:0] aAddr,
  output logic        aAck,
  output logic        aErr,
  output logic [63:0] aData,
  input  logic        bRd,
  input  logic        bWr,
  input  logic [2:0]  bMode,
  input  logic [47:0] bAddr,
  input  logic [63:0] bWrData,
  output logic        bAck,
  output logic        bErr,
  output logic [63:0] bData,
  output logic        tileRd,
  output logic        tileWr,
  output logic [2:0]  tileMode,
  output logic [47:0] tileAddr,
  output logic [63:0] tileWrData,
  input  logic [63:0] tileRdData
);

  localparam logic [3:0] LAT_LOAD = 4'(TILE_LAT);

  arb_state_e  state;
  logic        port_q;
  logic        wr_q;
  logic [3:0]  cnt;

  logic        grant_valid;
  logic        grant;
  logic [2:0]  sel_mode;
  logic [47:0] sel_addr;
  logic        sel_wr;
  logic        sel_err;

  rr_arb2 u_rr (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         ({bRd | bWr, aReq}),
    .accept      (state == IDLE),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_comb begin
    sel_mode = (grant == PORT_B) ? bMode : aMode;
    sel_addr = (grant == PORT_B) ? bAddr : aAddr;
    sel_wr   = (grant == PORT_B) && bWr;
    sel_err  = !mode_legal(sel_mode)
            || (sel_addr[47:14] != TILE_BASE)
            || ((grant == PORT_B) && bRd && bWr);
  end

  // Tile outputs double as the captured mode/address; ack/err pulse for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      port_q     <= PORT_A;
      wr_q       <= 1'b0;
      cnt        <= 4'd0;
      aAck       <= 1'b0;
      aErr       <= 1'b0;
      aData      <= 64'd0;
      bAck       <= 1'b0;
      bErr       <= 1'b0;
      bData      <= 64'd0;
      tileRd     <= 1'b0;
      tileWr     <= 1'b0;
      tileMode   <= 3'd0;
      tileAddr   <= 48'd0;
      tileWrData <= 64'd0;
    end else begin
      aAck <= 1'b0;
      aErr <= 1'b0;
      bAck <= 1'b0;
      bErr <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            port_q <= grant;
            wr_q   <= sel_wr;
            if (sel_err) begin
              state <= RESP;
              if (grant == PORT_B) begin
                bAck <= 1'b1;
                bErr <= 1'b1;
              end else begin
                aAck <= 1'b1;
                aErr <= 1'b1;
              end
            end else begin
              state      <= ISSUE;
              tileRd     <= !sel_wr;
              tileWr     <= sel_wr;
              tileMode   <= sel_mode;
              tileAddr   <= sel_addr;
              tileWrData <= sel_wr ? bWrData : 64'd0;
            end
          end
        end
        ISSUE: begin
          tileRd     <= 1'b0;
          tileWr     <= 1'b0;
          tileWrData <= 64'd0;
          cnt        <= LAT_LOAD;
          state      <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state    <= RESP;
            tileMode <= 3'd0;
            tileAddr <= 48'd0;
            if (port_q == PORT_B) begin
              bAck <= 1'b1;
              if (!wr_q) bData <= tileRdData;
            end else begin
              aAck  <= 1'b1;
              aData <= tileRdData;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_tile_arb.sv
// Randomised and directed bench for mem_tile_arb against a transaction-level
// model of the grant/check/latency rules, with a tile that returns data only late.
module tb_mem_tile_arb;
  import mem_tile_pkg::*;

  localparam int LAT  = 1;
  localparam int LAT4 = 4;
  localparam logic [63:0] JUNK = 64'hA5A5_5A5A_DEAD_0BAD;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        aReq = 1'b0;
  logic [2:0]  aMode = 3'd0;
  logic [47:0] aAddr = 48'd0;
  logic        aAck, aErr;
  logic [63:0] aData;
  logic        bRd = 1'b0, bWr = 1'b0;
  logic [2:0]  bMode = 3'd0;
  logic [47:0] bAddr = 48'd0;
  logic [63:0] bWrData = 64'd0;
  logic        bAck, bErr;
  logic [63:0] bData;
  logic        tileRd, tileWr;
  logic [2:0]  tileMode;
  logic [47:0] tileAddr;
  logic [63:0] tileWrData, tileRdData;

  logic        aReq4 = 1'b0;
  logic [2:0]  aMode4 = 3'd0;
  logic [47:0] aAddr4 = 48'd0;
  logic        aAck4, aErr4;
  logic [63:0] aData4;
  logic        bAck4, bErr4;
  logic [63:0] bData4;
  logic        tileRd4, tileWr4;
  logic [2:0]  tileMode4;
  logic [47:0] tileAddr4;
  logic [63:0] tileWrData4, tileRdData4;

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] rd_val = 64'd0;
  logic [63:0] exp_a_data = 64'd0;
  logic [63:0] exp_b_data = 64'd0;
  int t_cnt = 15;
  int t_cnt4 = 15;

  mem_tile_arb #(.TILE_BASE(34'h0), .TILE_LAT(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .aReq(aReq), .aMode(aMode), .aAddr(aAddr), .aAck(aAck), .aErr(aErr), .aData(aData),
    .bRd(bRd), .bWr(bWr), .bMode(bMode), .bAddr(bAddr), .bWrData(bWrData),
    .bAck(bAck), .bErr(bErr), .bData(bData),
    .tileRd(tileRd), .tileWr(tileWr), .tileMode(tileMode), .tileAddr(tileAddr),
    .tileWrData(tileWrData), .tileRdData(tileRdData)
  );

  mem_tile_arb #(.TILE_BASE(34'h0), .TILE_LAT(LAT4)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .aReq(aReq4), .aMode(aMode4), .aAddr(aAddr4), .aAck(aAck4), .aErr(aErr4), .aData(aData4),
    .bRd(1'b0), .bWr(1'b0), .bMode(3'd0), .bAddr(48'd0), .bWrData(64'd0),
    .bAck(bAck4), .bErr(bErr4), .bData(bData4),
    .tileRd(tileRd4), .tileWr(tileWr4), .tileMode(tileMode4), .tileAddr(tileAddr4),
    .tileWrData(tileWrData4), .tileRdData(tileRdData4)
  );

  // Tile model: read data is valid only in the LAT-th cycle after the strobe.
  always @(posedge clk) begin
    if (tileRd || tileWr) t_cnt <= 0;
    else if (t_cnt < 15) t_cnt <= t_cnt + 1;
    if (tileRd4 || tileWr4) t_cnt4 <= 0;
    else if (t_cnt4 < 15) t_cnt4 <= t_cnt4 + 1;
  end
  assign tileRdData  = (t_cnt == LAT - 1)   ? rd_val : JUNK;
  assign tileRdData4 = (t_cnt4 == LAT4 - 1) ? rd_val : JUNK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      $error("[TB] %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      check("strobe_excl", 64'(tileRd & tileWr), 64'd0);
      check("strobe_excl4", 64'(tileRd4 & tileWr4), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_err(input logic port_b, input logic rd, input logic wr,
                                   input logic [2:0] mode, input logic [47:0] addr);
    logic legal;
    legal = mode inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    return !legal || (addr >> 14) != 48'd0 || (port_b && rd && wr);
  endfunction

  // One complete transaction from IDLE: request, expected strobe and ack, release.
  task automatic access(input logic port_b, input logic rd, input logic wr,
                        input logic [2:0] mode, input logic [47:0] addr,
                        input logic [63:0] wdata, input logic [63:0] tile_val,
                        input string tag);
    logic err, is_rd, saw_rd, saw_wr;
    logic [2:0] s_mode;
    logic [47:0] s_addr;
    logic [63:0] s_wdata;
    int exp_edges, ack_at, strobes;
    err = ref_err(port_b, rd, wr, mode, addr);
    is_rd = port_b ? (rd && !wr) : 1'b1;
    exp_edges = err ? 1 : LAT + 2;
    rd_val = tile_val;
    if (!err && is_rd) begin
      if (port_b) exp_b_data = tile_val;
      else exp_a_data = tile_val;
    end
    if (port_b) begin
      bRd = rd; bWr = wr; bMode = mode; bAddr = addr; bWrData = wdata;
    end else begin
      aReq = 1'b1; aMode = mode; aAddr = addr;
    end
    ack_at = 0; strobes = 0; saw_rd = 0; saw_wr = 0;
    s_mode = 0; s_addr = 0; s_wdata = 0;
    for (int k = 1; k <= 30 && ack_at == 0; k++) begin
      step();
      if (tileRd || tileWr) begin
        strobes++;
        if (k == 1) begin
          saw_rd = tileRd; saw_wr = tileWr;
          s_mode = tileMode; s_addr = tileAddr; s_wdata = tileWrData;
        end
      end
      if (aAck || bAck) begin
        ack_at = k;
        check({tag, "_ack_b"}, 64'(bAck), 64'(port_b));
        check({tag, "_ack_a"}, 64'(aAck), 64'(!port_b));
        check({tag, "_err"}, 64'(port_b ? bErr : aErr), 64'(err));
        check({tag, "_adata"}, aData, exp_a_data);
        check({tag, "_bdata"}, bData, exp_b_data);
      end
    end
    aReq = 1'b0; bRd = 1'b0; bWr = 1'b0;
    check({tag, "_latency"}, 64'(ack_at), 64'(exp_edges));
    check({tag, "_strobes"}, 64'(strobes), err ? 64'd0 : 64'd1);
    if (!err) begin
      check({tag, "_tile_rd"}, 64'(saw_rd), 64'(is_rd));
      check({tag, "_tile_wr"}, 64'(saw_wr), 64'(!is_rd));
      check({tag, "_tile_mode"}, 64'(s_mode), 64'(mode));
      check({tag, "_tile_addr"}, 64'(s_addr), 64'(addr));
      check({tag, "_tile_wdata"}, s_wdata, is_rd ? 64'd0 : wdata);
    end
    step();
    check({tag, "_ack_pulse"}, 64'(aAck | bAck), 64'd0);
  endtask

  task automatic do_reset();
    aReq = 0; bRd = 0; bWr = 0; aReq4 = 0;
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    exp_a_data = 64'd0;
    exp_b_data = 64'd0;
  endtask

  function automatic logic any_out();
    return |{aAck, aErr, aData, bAck, bErr, bData, tileRd, tileWr,
             tileMode, tileAddr, tileWrData};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] rv;
    int ack_port[$];
    int ack_time[$];

    reset_n = 1'b0;
    repeat (2) step();
    check("reset_outs", 64'(any_out()), 64'd0);
    check("reset_outs4", 64'(|{aAck4, aData4, tileRd4, tileAddr4}), 64'd0);
    reset_n = 1'b1;
    step();

    access(PORT_A, 1, 0, MD_QWORD, 48'h10, 64'd0, 64'h1122334455667788, "a_qword");
    access(PORT_B, 0, 1, MD_DWORD, 48'h24, 64'hDEADBEEF, 64'h0, "b_write");
    access(PORT_B, 1, 0, MD_QWORD, 48'h0000_0000_4000, 64'd0, 64'h77, "b_oow");
    access(PORT_B, 1, 0, MD_NONE, 48'h40, 64'd0, 64'h78, "b_none");
    access(PORT_A, 1, 0, MD_OWORD, 48'h48, 64'd0, 64'h79, "a_oword");
    access(PORT_B, 1, 1, MD_WORD, 48'h50, 64'h5, 64'h7A, "b_rdwr");
    access(PORT_B, 1, 0, MD_UWORD, 48'h3FF8, 64'd0, 64'hCAFEF00D12345678, "b_top");

    // Both ports held high from reset: grants alternate starting with A.
    do_reset();
    rv = {$urandom, $urandom};
    rd_val = rv;
    aReq = 1; aMode = MD_QWORD; aAddr = 48'h100;
    bRd = 1; bMode = MD_WORD; bAddr = 48'h200;
    for (int k = 1; k <= 60 && ack_port.size() < 4; k++) begin
      step();
      if (aAck) begin ack_port.push_back(0); ack_time.push_back(k); end
      if (bAck) begin ack_port.push_back(1); ack_time.push_back(k); end
    end
    aReq = 0; bRd = 0;
    check("arb_count", 64'(ack_port.size()), 64'd4);
    for (int i = 0; i < ack_port.size(); i++) begin
      check("arb_order", 64'(ack_port[i]), 64'(i % 2));
      if (i > 0) check("arb_spacing", 64'(ack_time[i] - ack_time[i-1]), 64'(LAT + 3));
    end
    check("arb_adata", aData, rv);
    check("arb_bdata", bData, rv);
    exp_a_data = rv;
    exp_b_data = rv;
    repeat (2) step();

    // Reset in the middle of a valid read: everything clears, nothing acks.
    aReq = 1; aMode = MD_QWORD; aAddr = 48'h8;
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_outs", 64'(any_out()), 64'd0);
    aReq = 0;
    step();
    reset_n = 1'b1;
    exp_a_data = 64'd0;
    exp_b_data = 64'd0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("midreset_noack", 64'(aAck | bAck | tileRd | tileWr), 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic pb, r, w;
      logic [2:0] m;
      logic [47:0] ad;
      int sel;
      pb = 1'($urandom_range(0, 1));
      m = 3'($urandom_range(0, 7));
      ad = ($urandom_range(0, 4) == 0) ? {16'($urandom), 32'($urandom)} : {34'h0, 14'($urandom)};
      sel = $urandom_range(0, 9);
      r = pb ? (sel < 5 || sel == 9) : 1'b1;
      w = pb ? (sel >= 5) : 1'b0;
      access(pb, r, w, m, ad, {$urandom, $urandom}, {$urandom, $urandom}, "rand");
    end

    // Four-cycle tile: strobe one cycle after the request edge, ack five later.
    begin
      int s_at, a_at;
      s_at = 0; a_at = 0;
      rv = {$urandom, $urandom};
      rd_val = rv;
      aReq4 = 1; aMode4 = MD_UBYTE; aAddr4 = 48'h30;
      for (int k = 1; k <= 30 && a_at == 0; k++) begin
        step();
        if (tileRd4 && s_at == 0) begin
          s_at = k;
          check("lat4_addr", 64'(tileAddr4), 64'h30);
          check("lat4_mode", 64'(tileMode4), 64'(MD_UBYTE));
        end
        if (aAck4) begin
          a_at = k;
          check("lat4_err", 64'(aErr4), 64'd0);
          check("lat4_data", aData4, rv);
        end
      end
      aReq4 = 0;
      check("lat4_strobe_at", 64'(s_at), 64'd1);
      check("lat4_ack_at", 64'(a_at), 64'(LAT4 + 2));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_tile_arb.md
Name: mem_tile_arb

Overview:
- Two-requester arbiter and sequencer in front of the single-ported 64-bit memory tile (16 KiB window, 12-bit 32-bit-word index).
- Port A is the instruction-fetch side and is read-only; port B is the data side and can read or write.
- The block grants one requester at a time, checks mode and address window, drives one tile read/write strobe, and waits a fixed tile latency.
- It returns a registered, held result with a one-cycle acknowledge.

Parameters:
- TILE_BASE, 34'h0, value that memAddr[47:14] must equal for an access to be in-window.
- TILE_LAT, 1, cycles from strobe deassertion until tile read data is valid; legal range 1..15.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- aReq  in  1  port A request; held until aAck
- aMode  in  3  port A access mode (MD_* encoding)
- aAddr  in  48  port A byte address
- aAck  out  1  one-cycle response strobe for port A
- aErr  out  1  valid with aAck; request was rejected
- aData  out  64  port A read data; held until next port A response
- bRd  in  1  port B read request; held until bAck
- bWr  in  1  port B write request; held until bAck
- bMode  in  3  port B access mode
- bAddr  in  48  port B byte address
- bWrData  in  64  port B write data
- bAck  out  1  one-cycle response strobe for port B
- bErr  out  1  valid with bAck; request was rejected
- bData  out  64  port B read data; held until next port B read response
- tileRd  out  1  read strobe to tile
- tileWr  out  1  write strobe to tile
- tileMode  out  3  mode to tile
- tileAddr  out  48  address to tile
- tileWrData  out  64  write data to tile
- tileRdData  in  64  read data from tile

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low via reset_n.
- Reset values: every output 0; state IDLE; lastGrant = B, so A wins the first tie.
- Reset asserted mid-operation: abandon the access immediately, drop strobes, issue no ack. A write already strobed may have landed.
- State IDLE:
  - Sample requests. A request is aReq, or bRd|bWr.
  - Both requesting: grant the port not equal to lastGrant. One requesting: grant it.
  - On grant, capture mode, address and write data into registers and set lastGrant.
- Validity check at grant: a request is an error if any of the following holds.
  - mode is MD_NONE or MD_OWORD;
  - addr[47:14] != TILE_BASE;
  - port B has bRd and bWr both high;
  - port A mode is outside BYTE/WORD/DWORD/QWORD/UBYTE/UWORD (same rule as B).
- Error path: IDLE -> RESP. No tile strobe. Ack with Err=1 one cycle after the grant edge; the port's data output is unchanged.
- Valid path: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
  - ISSUE, exactly one cycle: tileRd or tileWr = 1. tileMode, tileAddr and tileWrData come from the captured registers; tileWrData = 0 for reads.
  - WAIT, TILE_LAT cycles: strobes 0, address and mode held, down-counter loaded with TILE_LAT.
  - On the last WAIT cycle of a read, capture tileRdData into aData or bData.
  - RESP, one cycle: Ack=1, Err=0.
- Latency: request seen at edge N gives strobe high in cycle N+1 and Ack high in cycle N+2+TILE_LAT. Error requests ack in cycle N+1.
- Writes return an ack; bData is not modified by writes.
- Back-to-back requests:
  - A requester may keep its request high after Ack to issue a new request; it is re-arbitrated in the IDLE cycle after RESP.
  - Minimum request spacing is TILE_LAT+3 cycles.
  - Round-robin guarantees each port is served at least every other grant.
- Requests that drop before Ack are protocol violations. The captured access still completes and is acked.
- Only one of tileRd/tileWr may ever be high; the bench asserts this.

Decomposition:
- Shared package mem_tile_pkg:
  - MD_NONE..MD_UWORD 3-bit encodings, as used by the tile;
  - arbiter state enum IDLE/ISSUE/WAIT/RESP;
  - port-ID constants PORT_A=0, PORT_B=1.
- Sub-module rr_arb2: two-input round-robin grant with a lastGrant register, reset to B. Reusable for other shared tiles.

Test Plan:
- Reset, then aReq with MD_QWORD at addr 0x10, tile returning 64'h1122334455667788 -> tileRd pulses in cycle 1; aAck and aData=64'h1122334455667788 in cycle 3 (TILE_LAT=1); aErr=0.
- bWr with MD_DWORD, addr 0x24, data 0xDEADBEEF -> single tileWr cycle with tileAddr 0x24, tileMode=3'b011, tileWrData 0xDEADBEEF; bAck, bErr=0; bData unchanged.
- aReq and bRd raised in the same cycle after reset, both held -> A is granted first and B next. With both held re-requesting, grants alternate A,B,A,B over 4 accesses.
- bRd at addr 48'h0000_0000_4000 with TILE_BASE=0 -> no tile strobe; bAck and bErr=1 in the next cycle. Repeat with bMode=MD_NONE for the same result.
- bRd and bWr both high -> error ack with no strobe. Then reset_n driven low during WAIT of a valid read -> all outputs 0 asynchronously and no ack after release.
- TILE_LAT=4 build, aReq MD_UBYTE -> strobe in cycle 1; aAck in cycle 6; aData captured in cycle 5 from tileRdData.
